load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 16, max REQ cycles without bus_ack before abort; legal 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 op_valid  in  1  CPU presents a load/store this cycle.
REQ-005 op_we  in  1  1 = store, 0 = load.
REQ-006 op_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 op_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-008 addr  in  32  byte address (ALU result).
REQ-009 wdata  in  32  store data (rs2 value), right-aligned.
REQ-010 stall  out  1  freeze CPU pipeline/PC.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 rdata  out  32  extended load result, valid while done=1.
REQ-013 misalign  out  1  illegal size/alignment, combinational.
REQ-014 bus_err  out  1  timeout indication, valid while done=1.
REQ-015 bus_req  out  1  bus request, held until ack or timeout.
REQ-016 bus_we, bus_addr[31:0], bus_be[3:0], bus_wdata[31:0]  out  registered bus command.
REQ-017 bus_ack  in  1; bus_rdata  in  32  bus response, rdata valid with ack.

Function
REQ-018 States IDLE, REQ, DONE; encoding free.
REQ-019 Misaligned = op_size 11, or half with addr[0]=1, or word with addr[1:0]!=00.
REQ-020 IDLE, op_valid=1, misaligned: misalign=1, stall=0, no bus activity, stay IDLE.
REQ-021 IDLE, op_valid=1, aligned: stall=1 same cycle (combinational); on edge latch command, go REQ.
REQ-022 bus_addr = {addr[31:2],2'b00}; bus_we = op_we.
REQ-023 bus_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; loads use same be.
REQ-024 bus_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-025 REQ: bus_req=1, stall=1, bus_* command stable every cycle.
REQ-026 REQ, bus_ack=1: capture extended load data (0 for stores), bus_err=0, go DONE next edge.
REQ-027 Load extraction little-endian: lane selected by latched addr[1:0], bits 8/16 extended per op_unsigned.
REQ-028 Wait counter resets on REQ entry, increments each REQ cycle without ack; at ACK_TIMEOUT cycles w/o ack -> DONE, bus_err=1, rdata=0.
REQ-029 Ack on same cycle counter reaches limit: ack wins, bus_err=0.
REQ-030 DONE: bus_req=0, stall=0, done=1 for exactly one cycle, op_valid ignored, return IDLE.
REQ-031 Latency: accept at cycle N, bus_req from N+1, ack at M -> done at M+1; back-to-back ops separated by the DONE cycle.
REQ-032 bus_ack outside REQ ignored; no state change.
REQ-033 Outside DONE: done=0, rdata holds last value, bus_err holds last value.

Reset
REQ-034 rst_n=0 at edge: state IDLE, bus_req/bus_we/done/bus_err=0, bus_addr/bus_be/bus_wdata/rdata=0, counter=0.
REQ-035 Reset mid-REQ abandons transaction; bus_req low after that edge; no done pulse.
REQ-036 stall and misalign are 0 while rst_n=0.

Verification
REQ-037 Store byte addr=0x103, wdata=0xAB, ack after 2 cycles -> bus_addr=0x100, be=1000, bus_wdata=0xABABABAB, done 1 cycle after ack.
REQ-038 Load half signed addr=0x202, bus_rdata=0x8001_7FFF -> rdata=0xFFFF8001; unsigned -> 0x00008001.
REQ-039 Load word addr=0x001 -> misalign=1, stall=0, bus_req never asserts.
REQ-040 No ack, ACK_TIMEOUT=4 -> bus_req 4 cycles, done=1 with bus_err=1, rdata=0; ack on cycle 4 -> bus_err=0.
REQ-041 rst_n=0 during REQ -> IDLE, bus_req=0 next cycle, no done; new op afterwards completes normally.
REQ-042 Back-to-back load then store, ack 0-wait -> bus_req one cycle each, DONE gap between, op_valid in DONE ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU load/store into a single bus transaction.
// Aligned ops stall the pipeline, issue a registered bus command and finish
// with a one-cycle done pulse. Misaligned ops are flagged and never reach the bus.
//
// state | meaning
// IDLE  | waiting for op_valid; flags misaligned ops combinationally
// REQ   | bus_req held with a stable command; waiting for ack or timeout
// DONE  | one-cycle completion pulse; rdata/bus_err valid; op_valid ignored
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        op_we,
    input  logic [1:0]  op_size,
    input  logic        op_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter compares against the last allowed no-ack cycle, so the
    // timeout fires on the ACK_TIMEOUT-th REQ cycle without ack.
    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic        accept;
    logic        is_misaligned;
    logic        timeout_hit;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [1:0]  lat_lane;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lane_data;
    logic [31:0] load_ext;

    // Alignment check and command formatting from the CPU-side inputs
    always_comb begin
        is_misaligned = (op_size == 2'b11)
                      || ((op_size == 2'b01) && addr[0])
                      || ((op_size == 2'b10) && (addr[1:0] != 2'b00));
        be_nxt    = 4'b1111;
        wdata_nxt = wdata;
        case (op_size)
            2'b00: begin
                be_nxt    = 4'b0001 << addr[1:0];
                wdata_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << addr[1:0];
                wdata_nxt = {2{wdata[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = wdata;
            end
        endcase
    end

    // Little-endian lane extraction and sign/zero extension of load data
    always_comb begin
        lane_data = bus_rdata >> {lat_lane, 3'b000};
        load_ext  = bus_rdata;
        case (lat_size)
            2'b00:   load_ext = {{24{~lat_unsigned & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_ext = {{16{~lat_unsigned & lane_data[15]}}, lane_data[15:0]};
            default: load_ext = bus_rdata;
        endcase
    end

    // Next-state and combinational handshake outputs
    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        misalign    = 1'b0;
        bus_req     = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        timeout_hit = (wait_cnt == CNT_LAST);
        case (state)
            IDLE: begin
                if (op_valid) begin
                    if (is_misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        accept    = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                if (bus_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Pipeline must not see stall/misalign while the unit is held in reset.
        if (!rst_n) begin
            stall    = 1'b0;
            misalign = 1'b0;
            accept   = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch, wait counter and response capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
            rdata        <= '0;
            bus_err      <= 1'b0;
            wait_cnt     <= '0;
            lat_lane     <= '0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
        end else begin
            if (accept) begin
                bus_we       <= op_we;
                bus_addr     <= {addr[31:2], 2'b00};
                bus_be       <= be_nxt;
                bus_wdata    <= wdata_nxt;
                lat_lane     <= addr[1:0];
                lat_size     <= op_size;
                lat_unsigned <= op_unsigned;
                wait_cnt     <= '0;
            end else if (state == REQ) begin
                if (bus_ack) begin
                    rdata   <= bus_we ? 32'd0 : load_ext;
                    bus_err <= 1'b0;
                end else if (timeout_hit) begin
                    rdata   <= 32'd0;
                    bus_err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

endmodule
